// File: rtl/decoder_scan_pkg.sv
// rtl/decoder_scan_pkg.sv - shared types and helpers for the decoder scan controller
// Purpose: FSM state encoding, index count and the wrapped next-set-bit search.
// Ports: none (package).
package decoder_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } scan_state_t;

   localparam int NUM_IDX = 4;

   // First set mask bit strictly after cur, wrapping 3->0; cur itself is the
   // last candidate so a single-bit mask returns the same index. Searching
   // from cur=3 therefore yields the lowest set bit.
   function automatic logic [1:0] next_idx(input logic [3:0] mask, input logic [1:0] cur);
      logic [1:0] r;
      logic [1:0] c;
      r = cur;
      for (int k = NUM_IDX; k >= 1; k--) begin
         c = cur + 2'(k);
         if (mask[c]) r = c;
      end
      return r;
   endfunction

endpackage

// File: rtl/decoder_scan_ctrl_if.sv
// rtl/decoder_scan_ctrl_if.sv - control/decoder signal bundle for decoder_scan_ctrl
// Purpose: groups scan control inputs and decoder drive outputs.
// Ports (signals): scan_en, digit_mask[3:0], duty[3:0] (only with SCAN_BRIGHTNESS_EN),
//   sel_a, sel_b, dec_en_n, digit_idx[1:0], slot_start.
// Modports: master = host driving scan control; slave = the scan controller.
interface decoder_scan_ctrl_if;
   logic       scan_en;
   logic [3:0] digit_mask;
`ifdef SCAN_BRIGHTNESS_EN
   logic [3:0] duty;
`endif
   logic       sel_a;
   logic       sel_b;
   logic       dec_en_n;
   logic [1:0] digit_idx;
   logic       slot_start;

`ifdef SCAN_BRIGHTNESS_EN
   modport master (output scan_en, digit_mask, duty,
                   input  sel_a, sel_b, dec_en_n, digit_idx, slot_start);
   modport slave  (input  scan_en, digit_mask, duty,
                   output sel_a, sel_b, dec_en_n, digit_idx, slot_start);
`else
   modport master (output scan_en, digit_mask,
                   input  sel_a, sel_b, dec_en_n, digit_idx, slot_start);
   modport slave  (input  scan_en, digit_mask,
                   output sel_a, sel_b, dec_en_n, digit_idx, slot_start);
`endif
endinterface

// File: rtl/scan_slot_counter.sv
// rtl/scan_slot_counter.sv - clear/enable counter with terminal-count flag
// Purpose: times blank gaps and drive slots for the scan FSM.
// Ports: clk, rst (sync, active high), clear, enable, term[CNT_W] (cycles per phase),
//   count[CNT_W] (cycles elapsed in phase), done (last cycle of phase).
module scan_slot_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] term,
   output logic [CNT_W-1:0] count,
   output logic             done
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

   assign done = enable && (count == term - CNT_W'(1));

endmodule

// File: rtl/decoder_scan_ctrl.sv
// rtl/decoder_scan_ctrl.sv - 2-to-4 decoder scan driver with blanking between slots
// Purpose: cycles the decoder select through the unmasked indices 0..3, holding the
//   decoder disabled for BLANK_CYCLES before each slot of SLOT_CYCLES enabled cycles.
// Ports: clk, rst (sync, active high), bus (decoder_scan_ctrl_if.slave):
//   scan_en, digit_mask in; sel_a, sel_b, dec_en_n, digit_idx, slot_start out.
// Option: SCAN_BRIGHTNESS_EN adds bus.duty; decoder enabled only for the first
//   (duty+1)*SLOT_CYCLES/16 cycles of each slot.
module decoder_scan_ctrl
   import decoder_scan_pkg::*;
#(
   parameter int SLOT_CYCLES  = 100000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   decoder_scan_ctrl_if.slave   bus
);

   localparam int MAX_C = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
   localparam int CNT_W = $clog2(MAX_C + 1);
   localparam int ON_W  = CNT_W + 5;

   scan_state_t      state;
   logic [1:0]       idx;
   logic [1:0]       idx_nxt;
   logic             dec_en_n_q;
   logic             slot_start_q;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] term;
   logic             done;
   logic             cnt_clear;
   logic [ON_W-1:0]  on_len;
   logic             drive_off_next;

   // Counter restarts on every state entry: leaving IDLE, at each phase end, or on abort.
   assign term      = (state == DRIVE) ? CNT_W'(SLOT_CYCLES) : CNT_W'(BLANK_CYCLES);
   assign cnt_clear = !bus.scan_en || (state == IDLE) || done;

   scan_slot_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (cnt_clear),
      .enable (state != IDLE),
      .term   (term),
      .count  (count),
      .done   (done)
   );

`ifdef SCAN_BRIGHTNESS_EN
   logic [3:0] duty_q;
   assign on_len = ((ON_W'(duty_q) + ON_W'(1)) * ON_W'(SLOT_CYCLES)) / ON_W'(16);
`else
   assign on_len = ON_W'(SLOT_CYCLES);
`endif
   // Decoder stays enabled while the next drive cycle is still within the on-time.
   assign drive_off_next = (ON_W'(count) + ON_W'(1)) >= on_len;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         idx          <= 2'd0;
         idx_nxt      <= 2'd0;
         dec_en_n_q   <= 1'b1;
         slot_start_q <= 1'b0;
`ifdef SCAN_BRIGHTNESS_EN
         duty_q       <= 4'd0;
`endif
      end else begin
         slot_start_q <= 1'b0;
         if (!bus.scan_en) begin
            state      <= IDLE;
            dec_en_n_q <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  dec_en_n_q <= 1'b1;
                  if (bus.digit_mask != 4'd0) begin
                     state   <= BLANK;
                     idx     <= next_idx(bus.digit_mask, 2'd3);
                     idx_nxt <= next_idx(bus.digit_mask, 2'd3);
                  end
               end
               BLANK: begin
                  // Select moves one cycle into the gap, so it never changes on the
                  // edge where the decoder turns off (needs BLANK_CYCLES >= 2).
                  idx <= idx_nxt;
                  if (done) begin
                     state        <= DRIVE;
                     dec_en_n_q   <= 1'b0;
                     slot_start_q <= 1'b1;
`ifdef SCAN_BRIGHTNESS_EN
                     duty_q       <= bus.duty;
`endif
                  end
               end
               DRIVE: begin
                  if (done) begin
                     dec_en_n_q <= 1'b1;
                     if (bus.digit_mask == 4'd0) begin
                        state <= IDLE;
                     end else begin
                        state   <= BLANK;
                        idx_nxt <= next_idx(bus.digit_mask, idx);
                     end
                  end else begin
                     dec_en_n_q <= drive_off_next;
                  end
               end
               default: begin
                  state      <= IDLE;
                  dec_en_n_q <= 1'b1;
               end
            endcase
         end
      end
   end

   assign bus.sel_a      = idx[1];
   assign bus.sel_b      = idx[0];
   assign bus.digit_idx  = idx;
   assign bus.dec_en_n   = dec_en_n_q;
   assign bus.slot_start = slot_start_q;

endmodule
